// File: rtl/lcd_ctrl_param.sv
// HD44780-class character LCD controller: power-up wait, cfg-driven init sequence,
// then host commands over valid/ready on an 8-bit or 4-bit (nibble) bus.
module lcd_ctrl_param #(
  parameter int CLK_PER_US   = 3,
  parameter int BUS_WIDTH    = 8,
  parameter int T_POWERUP_US = 500,
  parameter int T_EN_US      = 13,
  parameter int T_CMD_US     = 50,
  parameter int T_LONG_US    = 1640
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [6:0] cfg_i,
  input  logic       cmd_valid_i,
  input  logic [9:0] cmd_data_i,
  output logic       cmd_ready_o,
  output logic       e_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [7:0] lcd_data_o,
  output logic       busy_o,
  output logic       init_done_o
);
  localparam int PWR_CYC  = T_POWERUP_US * CLK_PER_US;
  localparam int SU_CYC   = CLK_PER_US;
  localparam int EN_CYC   = T_EN_US * CLK_PER_US;
  localparam int CMD_CYC  = T_CMD_US * CLK_PER_US;
  localparam int LONG_CYC = T_LONG_US * CLK_PER_US;
  localparam int MAX_A    = (PWR_CYC > LONG_CYC) ? PWR_CYC : LONG_CYC;
  localparam int MAX_B    = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
  localparam int MAX_CYC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = $clog2(MAX_CYC + 1);
  localparam logic [2:0] FIRST_STEP = (BUS_WIDTH == 4) ? 3'd0 : 3'd1;
  localparam logic [2:0] LAST_STEP  = 3'd4;

  if (BUS_WIDTH != 8 && BUS_WIDTH != 4) begin : g_bad_bus
    $error("lcd_ctrl_param: BUS_WIDTH must be 4 or 8");
  end

  typedef enum logic [2:0] {
    ST_POWERUP, ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW, ST_WAIT
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [6:0]    cfg_q;
  logic [7:0]    cmd_byte_q;
  logic          cmd_rs_q, cmd_rw_q;
  logic [2:0]    step_q;
  logic          lo_nib_q, single_q;
  logic          e_q, rs_q, rw_q, busy_q, ready_q, done_q;
  logic [7:0]    data_q;

  // Step 0 is the lone 0x2 nibble that switches the LCD into 4-bit mode.
  function automatic logic [7:0] init_byte(input logic [2:0] step, input logic [6:0] c);
    case (step)
      3'd0:    init_byte = 8'h20;
      3'd1:    init_byte = ((BUS_WIDTH == 4) ? 8'h20 : 8'h30) | {4'b0, c[6:5], 2'b0};
      3'd2:    init_byte = 8'h08 | {5'b0, c[4:2]};
      3'd3:    init_byte = 8'h01;
      default: init_byte = 8'h04 | {6'b0, c[1:0]};
    endcase
  endfunction

  function automatic logic [7:0] bus_val(input logic [7:0] b, input logic lo);
    if (BUS_WIDTH == 4) bus_val = lo ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
    else                bus_val = b;
  endfunction

  logic          hs, pwr_end, wait_end, init_next, start, long_cmd;
  logic [CW-1:0] wait_last;
  logic [2:0]    ld_step;
  logic [7:0]    ld_byte;
  logic          ld_rs, ld_rw, ld_single;

  always_comb begin
    long_cmd  = !cmd_rs_q && !cmd_rw_q && (cmd_byte_q[7:2] == 6'd0) && (cmd_byte_q != 8'd0);
    wait_last = long_cmd ? CW'(LONG_CYC - 1) : CW'(CMD_CYC - 1);
    hs        = (state_q == ST_IDLE) && cmd_valid_i && ready_q;
    pwr_end   = (state_q == ST_POWERUP) && (cnt_q == CW'(PWR_CYC - 1));
    wait_end  = (state_q == ST_WAIT) && (cnt_q == wait_last);
    init_next = wait_end && !done_q && (step_q != LAST_STEP);
    start     = pwr_end || init_next || hs;
    // cfg is captured on the same edge that launches the first init write
    ld_step   = (state_q == ST_POWERUP) ? FIRST_STEP : 3'(step_q + 3'd1);
    ld_byte   = init_byte(ld_step, (state_q == ST_POWERUP) ? cfg_i : cfg_q);
    ld_rs     = 1'b0;
    ld_rw     = 1'b0;
    ld_single = (ld_step == 3'd0);
    if (state_q == ST_IDLE) begin
      ld_byte   = cmd_data_i[7:0];
      ld_rs     = cmd_data_i[9];
      ld_rw     = cmd_data_i[8];
      ld_single = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_POWERUP;
      cnt_q      <= '0;
      cfg_q      <= '0;
      cmd_byte_q <= '0;
      cmd_rs_q   <= 1'b0;
      cmd_rw_q   <= 1'b0;
      step_q     <= '0;
      lo_nib_q   <= 1'b0;
      single_q   <= 1'b0;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        ST_POWERUP: if (pwr_end) cfg_q <= cfg_i;
        ST_IDLE:    cnt_q <= '0;
        ST_SETUP: if (cnt_q == CW'(SU_CYC - 1)) begin
          state_q <= ST_HIGH;
          cnt_q   <= '0;
          e_q     <= 1'b1;
        end
        ST_HIGH: if (cnt_q == CW'(EN_CYC - 1)) begin
          state_q <= ST_LOW;
          cnt_q   <= '0;
          e_q     <= 1'b0;
        end
        ST_LOW: if (cnt_q == CW'(EN_CYC - 1)) begin
          cnt_q <= '0;
          if (BUS_WIDTH == 4 && !lo_nib_q && !single_q) begin
            state_q  <= ST_SETUP;
            lo_nib_q <= 1'b1;
            data_q   <= bus_val(cmd_byte_q, 1'b1);
          end else begin
            state_q <= ST_WAIT;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            data_q  <= '0;
          end
        end
        ST_WAIT: if (wait_end) begin
          cnt_q <= '0;
          if (!init_next) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_POWERUP;
      endcase
      if (start) begin
        state_q    <= ST_SETUP;
        cnt_q      <= '0;
        cmd_byte_q <= ld_byte;
        cmd_rs_q   <= ld_rs;
        cmd_rw_q   <= ld_rw;
        if (!done_q) step_q <= ld_step;
        single_q   <= ld_single;
        lo_nib_q   <= 1'b0;
        e_q        <= 1'b0;
        rs_q       <= ld_rs;
        rw_q       <= ld_rw;
        data_q     <= bus_val(ld_byte, 1'b0);
        busy_q     <= 1'b1;
        ready_q    <= 1'b0;
      end
    end
  end

  assign cmd_ready_o = ready_q;
  assign e_o         = e_q;
  assign rs_o        = rs_q;
  assign rw_o        = rw_q;
  assign lcd_data_o  = data_q;
  assign busy_o      = busy_q;
  assign init_done_o = done_q;
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: an 8-bit and a 4-bit instance side by side, E pulses
// recorded by a monitor and compared with timing/data derived from the LCD rules.
module tb_lcd_ctrl_param;
  localparam int PWR = 1500, SU = 3, EN = 39, XF = SU + 2 * EN, WC = 150, WL = 4920;

  typedef struct {
    int data; int rsrw; int start; int width; int stable;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] cfg;
  logic [1:0] cv, rdy, e, rs, rw, busy, done;
  logic [9:0] cd [2];
  logic [7:0] lcd [2];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, t0 = 0;
  pulse_t pq [2][$];
  pulse_t cur [2];
  logic [1:0] e_prev = 2'b00;
  logic [9:0] cl [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_ctrl_param #(.BUS_WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_i(cfg), .cmd_valid_i(cv[0]), .cmd_data_i(cd[0]),
    .cmd_ready_o(rdy[0]), .e_o(e[0]), .rs_o(rs[0]), .rw_o(rw[0]), .lcd_data_o(lcd[0]),
    .busy_o(busy[0]), .init_done_o(done[0]));

  lcd_ctrl_param #(.BUS_WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_i(cfg), .cmd_valid_i(cv[1]), .cmd_data_i(cd[1]),
    .cmd_ready_o(rdy[1]), .e_o(e[1]), .rs_o(rs[1]), .rw_o(rw[1]), .lcd_data_o(lcd[1]),
    .busy_o(busy[1]), .init_done_o(done[1]));

  function automatic int idx();
    return cyc - t0;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, idx());
  endtask

  // E-pulse recorder: bus value, rs/rw, start cycle, width and stability while E is high
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (e[d] && !e_prev[d]) begin
        cur[d].data = int'(lcd[d]); cur[d].rsrw = int'({rs[d], rw[d]});
        cur[d].start = idx(); cur[d].width = 1; cur[d].stable = 1;
      end else if (e[d]) begin
        cur[d].width++;
        if (int'(lcd[d]) != cur[d].data || int'({rs[d], rw[d]}) != cur[d].rsrw) cur[d].stable = 0;
      end else if (e_prev[d]) begin
        pq[d].push_back(cur[d]);
      end
      e_prev[d] = e[d];
    end
  end

  task automatic check_init(input int d, input int c, input int td);
    int b [4];
    int ed [$];
    int es [$];
    int t, nx;
    b[0] = ((d == 1) ? 32 : 48) + ((c >> 5) & 3) * 4;
    b[1] = 8 + ((c >> 2) & 7);
    b[2] = 1;
    b[3] = 4 + (c & 3);
    t = PWR;
    nx = (d == 1) ? 2 : 1;
    if (d == 1) begin ed.push_back(32); es.push_back(t + SU); t += XF + WC; end
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < nx; n++) begin
        ed.push_back((d == 0) ? b[i] : (n == 0 ? (b[i] & 240) : (b[i] & 15) * 16));
        es.push_back(t + n * XF + SU);
      end
      t += nx * XF + ((b[i] == 1) ? WL : WC);
    end
    chk("init_done_time", td, t);
    chk("init_npulse", pq[d].size(), ed.size());
    for (int i = 0; i < ed.size() && i < pq[d].size(); i++) begin
      chk("init_data", pq[d][i].data, ed[i]);
      chk("init_start", pq[d][i].start, es[i]);
      chk("init_width", pq[d][i].width, EN);
      chk("init_rsrw", pq[d][i].rsrw, 0);
      chk("init_stable", pq[d][i].stable, 1);
    end
  endtask

  // One-cycle reset, cfg valid only on the last POWERUP cycle, then both inits checked
  task automatic do_init(input logic [6:0] cval);
    int td [2];
    int k;
    @(negedge clk);
    rst_n = 1'b0;
    cfg = ~cval;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk("reset_outputs", int'({e[d], rs[d], rw[d], lcd[d], busy[d], rdy[d], done[d]}), 4);
    rst_n = 1'b1;
    t0 = cyc;
    pq[0].delete();
    pq[1].delete();
    td[0] = -1;
    td[1] = -1;
    while (idx() < PWR - 1) @(negedge clk);
    cfg = cval;
    @(negedge clk);
    cfg = 7'($urandom);
    k = 0;
    while ((td[0] < 0 || td[1] < 0) && k < 12000) begin
      @(negedge clk);
      k++;
      for (int d = 0; d < 2; d++)
        if (td[d] < 0 && done[d]) begin
          td[d] = idx();
          chk("init_ready", int'(rdy[d]), 1);
          chk("idle_outputs", int'({e[d], rs[d], rw[d], lcd[d], busy[d]}), 0);
        end
    end
    for (int d = 0; d < 2; d++) check_init(d, int'(cval), td[d]);
  endtask

  task automatic run_cmd(input int d, input logic [9:0] cmd);
    int t, k, n0, nx, lat;
    bit lng;
    k = 0;
    while (!rdy[d] && k < 20000) begin @(negedge clk); k++; end
    chk("pre_ready", int'(rdy[d]), 1);
    n0 = pq[d].size();
    cd[d] = cmd;
    cv[d] = 1'b1;
    t = idx();
    @(negedge clk);
    cv[d] = 1'b0;
    cd[d] = 10'($urandom);
    repeat (9) @(negedge clk);
    cv[d] = 1'b1;
    @(negedge clk);
    cv[d] = 1'b0;
    k = 0;
    while (!rdy[d] && k < 6000) begin @(negedge clk); k++; end
    lat = idx() - t;
    lng = (cmd[9:8] == 2'b00) && (cmd[7:0] >= 8'd1) && (cmd[7:0] <= 8'd3);
    nx = (d == 1) ? 2 : 1;
    chk("cmd_latency", lat, 1 + nx * XF + (lng ? WL : WC));
    chk("cmd_npulse", pq[d].size() - n0, nx);
    for (int n = 0; n < nx && n0 + n < pq[d].size(); n++) begin
      chk("cmd_data", pq[d][n0 + n].data,
          (d == 0) ? int'(cmd[7:0]) : (n == 0 ? int'(cmd[7:4]) * 16 : int'(cmd[3:0]) * 16));
      chk("cmd_rsrw", pq[d][n0 + n].rsrw, int'(cmd[9:8]));
      chk("cmd_start", pq[d][n0 + n].start - t, SU + 1 + n * XF);
      chk("cmd_width", pq[d][n0 + n].width, EN);
      chk("cmd_stable", pq[d][n0 + n].stable, 1);
    end
  endtask

  task automatic run_seq(input int d);
    for (int i = 0; i < cl.size(); i++) run_cmd(d, cl[i]);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg = '0;
    cv = '0;
    cd[0] = '0;
    cd[1] = '0;
    repeat (3) @(negedge clk);
    do_init(7'b1111110);

    cl = '{10'h241, 10'h041, 10'h001, 10'h000, 10'h004, 10'h103, 10'h3FF};
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0) cl.push_back(10'($urandom_range(1, 3)));
      else cl.push_back(10'($urandom));
    end
    fork
      run_seq(0);
      run_seq(1);
    join

    // reset in the middle of a post-command wait on the 8-bit instance
    while (!rdy[0]) @(negedge clk);
    cd[0] = 10'h241;
    cv[0] = 1'b1;
    @(negedge clk);
    cv[0] = 1'b0;
    repeat (99) @(negedge clk);
    chk("midwait_busy", int'({busy[0], e[0], rdy[0]}), 4);
    do_init(7'($urandom));

    fork
      run_cmd(0, 10'h241);
      run_cmd(1, 10'h241);
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
